weight_loader: RTL and testbench

- Write-side counterpart of the neuron weight memory.
- Accepts a narrow byte stream over a valid/ready handshake, for example from a host or UART bridge.
- Packs the bytes little-endian into DATA_W-bit weight words.
- Writes each word to consecutive addresses of the weight RAM write port, starting at a programmable base address, then pulses done.

---
 rtl/weight_pkg.sv | 19 +
 rtl/word_packer.sv | 51 +++++
 rtl/weight_loader.sv | 121 ++++++++++++
 tb/tb_weight_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_pkg.sv
// Shared types and elaboration helpers for the weight memory loader.
package weight_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } state_e;

  function automatic int unsigned beats(input int unsigned data_w, input int unsigned in_w);
    return data_w / in_w;
  endfunction

  function automatic bit widths_ok(input int unsigned data_w, input int unsigned in_w);
    return (in_w != 0) && (data_w >= in_w) && ((data_w % in_w) == 0);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Packs narrow beats little-endian into a full word; the completed word is
// presented combinationally together with the beat that finishes it.
module word_packer
  import weight_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IN_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_accept,
  input  logic              i_clear,
  input  logic [IN_W-1:0]   i_data,
  output logic              o_word_valid_c,
  output logic [DATA_W-1:0] o_word_c
);

  localparam int unsigned BEATS = beats(DATA_W, IN_W);
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BW-1:0]     r_beat;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] w_word;
  logic              w_last;

  // Current beat merged into its lane of the partial word.
  always_comb begin
    w_word = r_word;
    for (int b = 0; b < int'(BEATS); b++) begin
      if (r_beat == BW'(b)) w_word[b*IN_W +: IN_W] = i_data;
    end
  end

  assign w_last         = (r_beat == BW'(BEATS - 1));
  assign o_word_valid_c = i_accept && w_last;
  assign o_word_c       = w_word;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_beat <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_beat <= '0;
      r_word <= '0;
    end else if (i_accept) begin
      r_word <= w_word;
      r_beat <= w_last ? '0 : r_beat + BW'(1);
    end
  end

endmodule

// File: rtl/weight_loader.sv
// Byte-stream to weight RAM loader: packs beats into words and writes them
// to consecutive addresses from a latched base, then pulses done.
module weight_loader
  import weight_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IN_W   = 8,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = ADDR_W + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  i_num_words,
  input  logic              i_in_valid,
  input  logic [IN_W-1:0]   i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_w_en,
  output logic [ADDR_W-1:0] o_mem_w_addr,
  output logic [DATA_W-1:0] o_mem_w_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_words_written
);

  if (!widths_ok(DATA_W, IN_W)) begin : g_bad_widths
    $error("weight_loader: DATA_W must be an integer multiple of IN_W");
  end

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_words_written;
  logic              r_mem_w_en;
  logic [ADDR_W-1:0] r_mem_w_addr;
  logic [DATA_W-1:0] r_mem_w_data;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_clear;
  logic              w_start_idle;
  logic              w_word_valid;
  logic [DATA_W-1:0] w_word;
  logic              w_last_word;

  assign o_in_ready   = (r_state == LOAD) && !i_abort;
  assign w_accept     = i_in_valid && o_in_ready;
  assign w_start_idle = (r_state == IDLE) && i_start;
  assign w_clear      = w_start_idle || ((r_state == LOAD) && i_abort);
  assign w_last_word  = ((r_words_written + CNT_W'(1)) == r_num);

  word_packer #(
    .DATA_W(DATA_W),
    .IN_W  (IN_W)
  ) u_packer (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_accept      (w_accept),
    .i_clear       (w_clear),
    .i_data        (i_in_data),
    .o_word_valid_c(w_word_valid),
    .o_word_c      (w_word)
  );

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (i_start) w_next = (i_num_words != '0) ? LOAD : DONE;
      LOAD: begin
        if (i_abort)                        w_next = IDLE;
        else if (w_word_valid && w_last_word) w_next = FLUSH;
      end
      FLUSH: w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= IDLE;
      r_base          <= '0;
      r_num           <= '0;
      r_words_written <= '0;
      r_mem_w_en      <= 1'b0;
      r_mem_w_addr    <= '0;
      r_mem_w_data    <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next == LOAD) || (w_next == FLUSH);
      r_done     <= (w_next == DONE);
      r_mem_w_en <= w_word_valid;
      if (w_start_idle) begin
        r_base          <= i_base_addr;
        r_num           <= i_num_words;
        r_words_written <= '0;
      end
      // Address wraps modulo the memory depth.
      if (w_word_valid) begin
        r_mem_w_addr    <= r_base + r_words_written[ADDR_W-1:0];
        r_mem_w_data    <= w_word;
        r_words_written <= r_words_written + CNT_W'(1);
      end
    end
  end

  assign o_mem_w_en      = r_mem_w_en;
  assign o_mem_w_addr    = r_mem_w_addr;
  assign o_mem_w_data    = r_mem_w_data;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_words_written = r_words_written;

endmodule

// File: tb/tb_weight_loader.sv
// Directed-plus-random bench for weight_loader against a byte-list reference model.
module tb_weight_loader;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IN_W   = 8;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  num_words = '0;
  logic              in_valid = 1'b0;
  logic [IN_W-1:0]   in_data = '0;
  logic              in_ready;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [DATA_W-1:0] mem_w_data;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  words_written;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [ADDR_W-1:0] wa[$];
  logic [DATA_W-1:0] wd[$];
  int                wc[$];
  int                done_cnt = 0;
  int                done_cyc = 0;

  weight_loader #(
    .DATA_W(DATA_W), .IN_W(IN_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_abort        (abort),
    .i_base_addr    (base_addr),
    .i_num_words    (num_words),
    .i_in_valid     (in_valid),
    .i_in_data      (in_data),
    .o_in_ready     (in_ready),
    .o_mem_w_en     (mem_w_en),
    .o_mem_w_addr   (mem_w_addr),
    .o_mem_w_data   (mem_w_data),
    .o_busy         (busy),
    .o_done         (done),
    .o_words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_w_en === 1'b1) begin
      wa.push_back(mem_w_addr);
      wd.push_back(mem_w_data);
      wc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
    start = 1'b1;
    base_addr = b;
    num_words = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input bq_t b, input bit throttle);
    for (int i = 0; i < b.size(); i++) begin
      bit acc = 1'b0;
      int budget = 0;
      in_data = b[i];
      while (!acc && budget < 200) begin
        in_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) last_acc = cyc + 1;
        tick();
        budget++;
      end
      if (!acc) chk("accept_timeout", 64'(0), 64'(1));
    end
    in_valid = 1'b0;
  endtask

  function automatic bq_t rnd_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Reference: word w is bytes 4w..4w+3 little-endian at (base+w) mod 1024.
  task automatic check_writes(input string tag, input int first, input int base,
                              input int n, input bq_t b);
    chk({tag, "_count"}, 64'(wa.size() - first), 64'(n));
    for (int w = 0; w < n && (first + w) < wa.size(); w++) begin
      longint unsigned exp_d = 0;
      for (int k = 0; k < 4; k++) exp_d += longint'(b[4*w+k]) * (longint'(1) << (8*k));
      chk({tag, "_addr"}, 64'(wa[first+w]), 64'((base + w) % 1024));
      chk({tag, "_data"}, 64'(wd[first+w]), 64'(exp_d));
    end
  endtask

  task automatic wait_idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    bq_t fixed = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    bq_t rb;
    int  first;
    int  d0;
    int  base;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_w_en", 64'(mem_w_en), 64'(0));
    chk("rst_w_addr", 64'(mem_w_addr), 64'(0));
    chk("rst_w_data", 64'(mem_w_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_words", 64'(words_written), 64'(0));

    // Basic load, continuous valid
    first = wa.size();
    d0 = done_cnt;
    start_load(10'h010, 11'd2);
    @(negedge clk);
    chk("basic_busy", 64'(busy), 64'(1));
    chk("basic_ready", 64'(in_ready), 64'(1));
    tick();
    send(fixed, 1'b0);
    wait_idle(4);
    check_writes("basic", first, 'h010, 2, fixed);
    if (wa.size() - first == 2) begin
      chk("basic_backtoback", 64'(wc[first+1] - wc[first]), 64'(4));
      chk("basic_wr_cycle", 64'(wc[first+1]), 64'(last_acc));
    end
    chk("basic_done_cnt", 64'(done_cnt - d0), 64'(1));
    chk("basic_done_cycle", 64'(done_cyc), 64'(last_acc + 1));
    chk("basic_words", 64'(words_written), 64'(2));
    chk("basic_busy_end", 64'(busy), 64'(0));

    // Throttled streams: fixed data, then random data at a random base
    first = wa.size();
    start_load(10'h010, 11'd2);
    send(fixed, 1'b1);
    wait_idle(4);
    check_writes("throttle", first, 'h010, 2, fixed);
    base = int'($urandom_range(0, 1023));
    rb = rnd_bytes(12);
    first = wa.size();
    start_load(10'(base), 11'd3);
    send(rb, 1'b1);
    wait_idle(4);
    check_writes("throttle_rnd", first, base, 3, rb);
    chk("throttle_words", 64'(words_written), 64'(3));

    // Address wrap
    rb = rnd_bytes(8);
    first = wa.size();
    start_load(10'h3FF, 11'd2);
    send(rb, 1'b0);
    wait_idle(4);
    check_writes("wrap", first, 'h3FF, 2, rb);

    // Zero count: done without any write
    first = wa.size();
    d0 = done_cnt;
    start_load(10'h123, 11'd0);
    wait_idle(4);
    chk("zero_writes", 64'(wa.size() - first), 64'(0));
    chk("zero_done_cnt", 64'(done_cnt - d0), 64'(1));

    // Abort mid-word together with a valid beat
    rb = rnd_bytes(6);
    first = wa.size();
    d0 = done_cnt;
    start_load(10'h040, 11'd3);
    send(rb, 1'b0);
    in_valid = 1'b1;
    abort = 1'b1;
    in_data = 8'hA5;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'(0));
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_idle_ready", 64'(in_ready), 64'(0));
    wait_idle(4);
    check_writes("abort", first, 'h040, 1, rb);
    chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_words", 64'(words_written), 64'(1));
    rb = rnd_bytes(4);
    first = wa.size();
    start_load(10'h020, 11'd1);
    send(rb, 1'b0);
    wait_idle(4);
    check_writes("reload", first, 'h020, 1, rb);

    // Asynchronous reset between edges during LOAD
    first = wa.size();
    d0 = done_cnt;
    start_load(10'h050, 11'd2);
    send(rnd_bytes(2), 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_ready", 64'(in_ready), 64'(0));
    chk("arst_w_en", 64'(mem_w_en), 64'(0));
    chk("arst_w_addr", 64'(mem_w_addr), 64'(0));
    chk("arst_w_data", 64'(mem_w_data), 64'(0));
    chk("arst_words", 64'(words_written), 64'(0));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("arst_no_write", 64'(wa.size() - first), 64'(0));
    chk("arst_no_done", 64'(done_cnt - d0), 64'(0));

    // Start while busy is ignored
    rb = rnd_bytes(8);
    first = wa.size();
    start_load(10'h100, 11'd2);
    send(rb[0:1], 1'b0);
    start = 1'b1;
    base_addr = 10'h200;
    num_words = 11'd5;
    tick();
    start = 1'b0;
    send(rb[2:7], 1'b0);
    wait_idle(4);
    check_writes("busy_start", first, 'h100, 2, rb);
    chk("busy_start_words", 64'(words_written), 64'(2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
